// File: rtl/wb_port_arbiter_8_pkg.sv
// Shared types and constants for the 8-way round-robin write-port arbiter.
package wb_port_arbiter_8_pkg;

  localparam int NUM_REQ = 8;
  localparam int SEL_W   = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/wb_port_arbiter_8_if.sv
// Requester-side and downstream-side bus of the arbiter; master is the arbiter view.
interface wb_port_arbiter_8_if #(parameter int WIDTH = 32);
  logic [7:0]       req;
  logic [WIDTH-1:0] in0, in1, in2, in3, in4, in5, in6, in7;
  logic [7:0]       ack;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_src;
  logic             busy;

  modport master (
    input  req, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
    output ack, out_valid, out_data, out_src, busy
  );

  modport slave (
    output req, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
    input  ack, out_valid, out_data, out_src, busy
  );
endinterface

// File: rtl/wb_port_arbiter_8_mux.sv
// Generic 8-input data mux used for the selected requester word.
module wb_port_arbiter_8_mux #(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       sel,
  input  logic [WIDTH-1:0] in0, in1, in2, in3, in4, in5, in6, in7,
  output logic [WIDTH-1:0] y
);
  always_comb begin
    y = in0;
    case (sel)
      3'd0: y = in0;
      3'd1: y = in1;
      3'd2: y = in2;
      3'd3: y = in3;
      3'd4: y = in4;
      3'd5: y = in5;
      3'd6: y = in6;
      3'd7: y = in7;
      default: y = in0;
    endcase
  end
endmodule

// File: rtl/wb_port_arbiter_8_rr_pick_8.sv
// Round-robin pick: rotate so last_ptr+1 sits at bit 0, find lowest set bit, un-rotate.
module rr_pick_8
  import wb_port_arbiter_8_pkg::*;
(
  input  logic [NUM_REQ-1:0] elig,
  input  logic [SEL_W-1:0]   last_ptr,
  output logic [SEL_W-1:0]   pick,
  output logic               any
);
  logic [SEL_W-1:0]     start;
  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [SEL_W-1:0]     idx;

  always_comb begin
    start = last_ptr + 3'd1;
    dbl   = {elig, elig} >> start;
    rot   = dbl[NUM_REQ-1:0];
    idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) idx = SEL_W'(i);
    end
    pick = idx + start;
    any  = |elig;
  end
endmodule

// File: rtl/wb_port_arbiter_8.sv
// Round-robin arbiter sharing one registered output port among 8 requesters,
// with valid/ready downstream handshake and one-cycle ack to the winner.
module wb_port_arbiter_8
  import wb_port_arbiter_8_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [SEL_W-1:0] RESET_PTR = 3'd7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  wb_port_arbiter_8_if.master bus
);
  state_t               state_q, state_d;
  logic [SEL_W-1:0]     last_ptr_q, last_ptr_d;
  logic [SEL_W-1:0]     src_q, src_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic [NUM_REQ-1:0]   elig;
  logic [SEL_W-1:0]     pick;
  logic                 any;
  logic                 capture;
  logic [WIDTH-1:0]     mux_y;

  // A requester is masked while its own ack is high so a stale level is not re-captured.
  assign elig = bus.req & ~ack_q;

  rr_pick_8 u_pick (
    .elig     (elig),
    .last_ptr (last_ptr_q),
    .pick     (pick),
    .any      (any)
  );

  wb_port_arbiter_8_mux #(.WIDTH(WIDTH)) u_mux (
    .sel (pick),
    .in0 (bus.in0), .in1 (bus.in1), .in2 (bus.in2), .in3 (bus.in3),
    .in4 (bus.in4), .in5 (bus.in5), .in6 (bus.in6), .in7 (bus.in7),
    .y   (mux_y)
  );

  assign capture = ((state_q == ST_EMPTY) || bus.out_ready) && en && any;

  always_comb begin
    state_d    = state_q;
    last_ptr_d = last_ptr_q;
    src_d      = src_q;
    data_d     = data_q;
    ack_d      = '0;
    if (capture) begin
      state_d    = ST_FULL;
      last_ptr_d = pick;
      src_d      = pick;
      data_d     = mux_y;
      ack_d      = NUM_REQ'(1) << pick;
    end else if (state_q == ST_FULL && bus.out_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      last_ptr_q <= RESET_PTR;
      src_q      <= '0;
      data_q     <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_ptr_q <= last_ptr_d;
      src_q      <= src_d;
      data_q     <= data_d;
      ack_q      <= ack_d;
    end
  end

  assign bus.out_valid = (state_q == ST_FULL);
  assign bus.busy      = (state_q == ST_FULL);
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
  assign bus.ack       = ack_q;
endmodule

// File: tb/tb_wb_port_arbiter_8.sv
// Directed bench for wb_port_arbiter_8: vector table for rotation plus hand sequences.
module tb_wb_port_arbiter_8;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic en    = 1'b1;
  int   tests = 0;
  int   fails = 0;

  wb_port_arbiter_8_if #(.WIDTH(32)) bus ();

  wb_port_arbiter_8 #(.WIDTH(32), .RESET_PTR(3'd7)) dut (
    .clock (clock),
    .reset (reset),
    .en    (en),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  req;
    logic        en;
    logic        rdy;
    logic        exp_valid;
    logic [2:0]  exp_src;
    logic [7:0]  exp_ack;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string name, input logic v, input logic [2:0] s,
                         input logic [7:0] a, input logic [31:0] d);
    chk({name, ".valid"}, 32'(bus.out_valid), 32'(v));
    chk({name, ".busy"},  32'(bus.busy),      32'(v));
    chk({name, ".src"},   32'(bus.out_src),   32'(s));
    chk({name, ".ack"},   32'(bus.ack),       32'(a));
    chk({name, ".data"},  bus.out_data,       d);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    bus.req = 8'h00; bus.out_ready = 1'b1;
    bus.in0 = 32'd1; bus.in1 = 32'd2; bus.in2 = 32'd3; bus.in3 = 32'd4;
    bus.in4 = 32'd5; bus.in5 = 32'd6; bus.in6 = 32'd7; bus.in7 = 32'd8;

    // Rotation with all requesting, then a lone requester throttled to every other cycle.
    for (int i = 0; i < 8; i++)
      vecs[i] = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'(i), 8'(1 << i), 32'(i + 1)};
    vecs[8]  = '{8'hFF, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 32'd1};
    vecs[9]  = '{8'h01, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 32'd1};
    vecs[10] = '{8'h01, 1'b1, 1'b1, 1'b1, 3'd0, 8'h01, 32'd1};
    vecs[11] = '{8'h01, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00, 32'd1};

    // Idle after reset
    #2;
    chk_out("reset", 1'b0, 3'd0, 8'h00, 32'h0);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      step();
      chk_out("idle", 1'b0, 3'd0, 8'h00, 32'h0);
    end

    // Single capture then drop
    bus.req = 8'h01; bus.in0 = 32'hDEAD_BEEF;
    step();
    chk_out("single", 1'b1, 3'd0, 8'h01, 32'hDEAD_BEEF);
    bus.req = 8'h00;
    step();
    chk_out("drain", 1'b0, 3'd0, 8'h00, 32'hDEAD_BEEF);

    // Table: back-to-back rotation
    do_reset();
    bus.in0 = 32'd1;
    for (int i = 0; i < 12; i++) begin
      bus.req = vecs[i].req; en = vecs[i].en; bus.out_ready = vecs[i].rdy;
      step();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_src,
              vecs[i].exp_ack, vecs[i].exp_data);
    end

    // Backpressure holds the captured word
    bus.req = 8'h00;
    do_reset();
    bus.in3 = 32'h3333_0000; bus.in4 = 32'h4444_0000; bus.in5 = 32'h5555_0000;
    bus.req = 8'h08; bus.out_ready = 1'b0;
    step();
    chk_out("bp_cap", 1'b1, 3'd3, 8'h08, 32'h3333_0000);
    bus.req = 8'h30;
    for (int c = 0; c < 4; c++) begin
      step();
      chk_out("bp_hold", 1'b1, 3'd3, 8'h00, 32'h3333_0000);
    end
    bus.out_ready = 1'b1;
    step();
    chk_out("bp_g4", 1'b1, 3'd4, 8'h10, 32'h4444_0000);
    step();
    chk_out("bp_g5", 1'b1, 3'd5, 8'h20, 32'h5555_0000);

    // Fairness from last_ptr=5
    bus.req = 8'h00;
    step();
    chk_out("fair_drain", 1'b0, 3'd5, 8'h00, 32'h5555_0000);
    bus.in0 = 32'h0000_0A00; bus.req = 8'h21;
    step();
    chk_out("fair_g0", 1'b1, 3'd0, 8'h01, 32'h0000_0A00);
    step();
    chk_out("fair_g5", 1'b1, 3'd5, 8'h20, 32'h5555_0000);

    // en=0 blocks capture but the pending word drains
    bus.req = 8'h04; en = 1'b0;
    step();
    chk_out("en0_drain", 1'b0, 3'd5, 8'h00, 32'h5555_0000);
    for (int c = 0; c < 2; c++) begin
      step();
      chk_out("en0_idle", 1'b0, 3'd5, 8'h00, 32'h5555_0000);
    end
    en = 1'b1;
    step();
    chk_out("en1_g2", 1'b1, 3'd2, 8'h04, 32'd3);

    // Async reset mid-transfer clears without a clock edge
    bus.out_ready = 1'b0; bus.req = 8'h00;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk_out("async_rst", 1'b0, 3'd0, 8'h00, 32'h0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.req = 8'h0C; bus.out_ready = 1'b1;
    step();
    chk_out("post_rst", 1'b1, 3'd2, 8'h04, 32'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter_8.md
Name: wb_port_arbiter_8

Overview:
- Round-robin arbiter that shares one 32-bit output port among 8 requesters. Typical uses are the register-file write port and the memory request port.
- Selects one requester, drives the 3-bit select of an 8-way 32-bit mux, and captures the selected word into an output register.
- Presents the captured word downstream with a valid/ready handshake and returns a one-cycle ack to the winning requester.

Parameters:
- WIDTH, 32, data width of every input and of out_data.
- RESET_PTR, 3'd7, reset value of the last-grant pointer. The default gives requester 0 first priority after reset.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- en  input  1  when 0, no new capture is made; the held output is unaffected
- req  input  8  level request; bit i belongs to requester i
- in0..in7  input  WIDTH each  data from requester 0..7
- ack  output  8  one-hot, one-cycle pulse; requester i's word has been captured
- out_valid  output  1  out_data is valid
- out_ready  input  1  downstream accepts out_data
- out_data  output  WIDTH  captured word
- out_src  output  3  index of the requester that supplied out_data
- busy  output  1  equals out_valid; exported for stall logic

Behaviour:
- Reset (async, active-high): out_valid=0, out_data=0, out_src=0, ack=0, last_ptr=RESET_PTR, state=EMPTY.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
- Capture opportunity: state==EMPTY, or state==FULL with out_ready=1.
- Eligible set: elig = req & ~ack. A requester is masked in the cycle its ack is high, so it must drop req (or present new data) by the following cycle.
- Pick: the first set bit of elig scanning circularly from last_ptr+1 (mod 8) up to last_ptr. last_ptr itself is lowest priority.
- Capture edge (capture opportunity && en && elig!=0):
  - out_data <= mux output selected by the pick
  - out_src <= pick
  - out_valid <= 1
  - ack <= 1<<pick
  - last_ptr <= pick
  - state <= FULL
- FULL && out_ready && (en==0 || elig==0): out_valid <= 0, state <= EMPTY, ack <= 0.
- FULL && !out_ready: out_data, out_src and out_valid hold stable; ack <= 0. req is ignored.
- ack is high for exactly one cycle per capture. It is never high for two requesters.
- Latency: req asserted in cycle N with state EMPTY gives out_valid=1 and ack in cycle N+1.
- Throughput: with out_ready held at 1 and continuous requests, one word per cycle (back-to-back capture).
- en=0: no capture and last_ptr frozen. A pending output still drains on out_ready.
- Single requester: it wins on every opportunity but is masked in its own ack cycle, so its maximum rate is one word per 2 cycles.
- Wrap-around: last_ptr=7 scans 0,1,...,7.
- Reset asserted mid-transfer: the word is discarded, the output clears immediately (asynchronously), and no ack is issued.
- Out-of-range values cannot occur; all index arithmetic is 3-bit modulo 8.

Decomposition:
- Shared package:
  - state encoding constants ST_EMPTY=1'b0, ST_FULL=1'b1
  - NUM_REQ=8, SEL_W=3
- Sub-module rr_pick_8, combinational:
  - inputs: elig[7:0], last_ptr[2:0]
  - outputs: pick[2:0], any
  - implementation: rotate, priority-encode, un-rotate.
- Data selection reuses the team's existing 8-input 32-bit mux, with select driven by pick. The top level holds the FSM, the registers and the ack generation.

Test Plan:
1. Reset, then req=8'h00 for 5 cycles -> out_valid=0, ack=0, out_data=0 throughout.
2. After reset: req=8'h01, in0=32'hDEAD_BEEF, out_ready=1 -> next cycle out_valid=1, out_data=32'hDEADBEEF, out_src=0, ack=8'h01. Drop req -> out_valid=0 one cycle later.
3. req=8'hFF held, out_ready=1, each requester i drives i+1 -> out_src sequence 0,1,2,...,7,0 across consecutive cycles, one ack bit per cycle, out_data=out_src+1.
4. Backpressure: capture from requester 3 (in3=32'h3333_0000), hold out_ready=0 for 4 cycles with req=8'h30 -> out_data stays 32'h33330000, out_src=3, ack=0. Raise out_ready -> next capture is requester 4, then 5.
5. Fairness: last_ptr=5, req=8'h21 -> grant 0 before 5. Then requester 0 stays masked for its ack cycle -> next grant 5.
6. en=0 with req=8'h04 -> no capture. Assert reset while out_valid=1 -> out_valid drops with no clock edge needed. After release, first grant goes to the lowest set req bit.
